// File: rtl/path_tracer.sv
// Search controller and path back-tracer: resets and seeds the node grid, waits for
// relaxation to go quiet, then streams the pointer chain from destination to source.
module path_tracer #(
  parameter int GRID_W    = 16,
  parameter int GRID_H    = 16,
  parameter int XW        = 4,
  parameter int YW        = 4,
  parameter int SETTLE    = 8,
  parameter int MAX_STEPS = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] src_x,
  input  logic [YW-1:0] src_y,
  input  logic [XW-1:0] dst_x,
  input  logic [YW-1:0] dst_y,
  input  logic          any_mod,
  output logic          grid_rst,
  output logic          grid_clr,
  output logic [XW-1:0] clr_x,
  output logic [YW-1:0] clr_y,
  output logic [XW-1:0] rd_x,
  output logic [YW-1:0] rd_y,
  input  logic [2:0]    rd_dir,
  input  logic [11:0]   rd_cost,
  output logic          step_valid,
  input  logic          step_ready,
  output logic [XW-1:0] step_x,
  output logic [YW-1:0] step_y,
  output logic          step_last,
  output logic          busy,
  output logic          done,
  output logic          fail
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int SW = $clog2(MAX_STEPS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GRST, S_SEED, S_SETTLE, S_CHECK, S_TRACE, S_FIN
  } state_t;

  state_t        state, state_nxt;
  logic [XW-1:0] dst_x_q;
  logic [YW-1:0] dst_y_q;
  logic [CW-1:0] quiet_q;
  logic [SW-1:0] steps_q;

  logic          go_n, go_s, go_e, go_w;
  logic          off_grid, limit_hit, abort, unreachable, handshake, quiet_done;
  logic [XW-1:0] nxt_x;
  logic [YW-1:0] nxt_y;

  logic          grid_rst_d, grid_clr_d, step_valid_d, step_last_d;
  logic          busy_d, done_d, fail_d;
  logic [XW-1:0] step_x_d;
  logic [YW-1:0] step_y_d;

  // The current step coordinate doubles as the trace cursor.
  always_comb begin
    go_n = rd_dir inside {3'd7, 3'd0, 3'd1};
    go_s = rd_dir inside {3'd3, 3'd4, 3'd5};
    go_e = rd_dir inside {3'd1, 3'd2, 3'd3};
    go_w = rd_dir inside {3'd5, 3'd6, 3'd7};
    nxt_x = step_x;
    if (go_e)      nxt_x = step_x + 1'b1;
    else if (go_w) nxt_x = step_x - 1'b1;
    nxt_y = step_y;
    if (go_s)      nxt_y = step_y + 1'b1;
    else if (go_n) nxt_y = step_y - 1'b1;
    off_grid = (go_w && step_x == '0) || (go_e && step_x >= XW'(GRID_W - 1)) ||
               (go_n && step_y == '0) || (go_s && step_y >= YW'(GRID_H - 1));
    limit_hit   = (steps_q + 1'b1) == SW'(MAX_STEPS);
    abort       = off_grid || limit_hit;
    unreachable = (rd_cost == 12'hFFF);
    handshake   = step_valid && step_ready;
    quiet_done  = (quiet_q + 1'b1) == CW'(SETTLE);
  end

  always_comb begin
    rd_x = '0;
    rd_y = '0;
    case (state)
      S_CHECK: begin rd_x = dst_x_q; rd_y = dst_y_q; end
      S_TRACE: begin rd_x = step_x;  rd_y = step_y;  end
      default: ;
    endcase
  end

  // Start is ignored while busy, including the abort cycle spent in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start && !busy) state_nxt = S_GRST;
      S_GRST:   state_nxt = S_SEED;
      S_SEED:   state_nxt = S_SETTLE;
      S_SETTLE: if (!any_mod && quiet_done) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = unreachable ? S_IDLE : S_TRACE;
      S_TRACE:  if (handshake) begin
                  if (step_last)  state_nxt = S_FIN;
                  else if (abort) state_nxt = S_IDLE;
                end
      S_FIN:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    fail_d       = ((state == S_CHECK) && unreachable) ||
                   ((state == S_TRACE) && handshake && !step_last && abort);
    grid_rst_d   = (state_nxt == S_GRST);
    grid_clr_d   = (state_nxt == S_SEED);
    done_d       = (state_nxt == S_FIN);
    busy_d       = (state_nxt != S_IDLE) || fail_d;
    step_valid_d = (state_nxt == S_TRACE);
    step_x_d     = step_x;
    step_y_d     = step_y;
    if (state == S_CHECK) begin
      step_x_d = dst_x_q;
      step_y_d = dst_y_q;
    end else if (state == S_TRACE && state_nxt == S_TRACE && handshake) begin
      step_x_d = nxt_x;
      step_y_d = nxt_y;
    end
    step_last_d = step_valid_d && (step_x_d == clr_x) && (step_y_d == clr_y);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      dst_x_q    <= '0;
      dst_y_q    <= '0;
      clr_x      <= '0;
      clr_y      <= '0;
      quiet_q    <= '0;
      steps_q    <= '0;
      grid_rst   <= 1'b0;
      grid_clr   <= 1'b0;
      step_valid <= 1'b0;
      step_x     <= '0;
      step_y     <= '0;
      step_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= state_nxt;
      grid_rst   <= grid_rst_d;
      grid_clr   <= grid_clr_d;
      step_valid <= step_valid_d;
      step_x     <= step_x_d;
      step_y     <= step_y_d;
      step_last  <= step_last_d;
      busy       <= busy_d;
      done       <= done_d;
      fail       <= fail_d;
      if (state == S_IDLE && state_nxt == S_GRST) begin
        clr_x   <= src_x;
        clr_y   <= src_y;
        dst_x_q <= dst_x;
        dst_y_q <= dst_y;
      end
      if (state == S_SEED)        quiet_q <= '0;
      else if (state == S_SETTLE) quiet_q <= any_mod ? '0 : quiet_q + 1'b1;
      if (state == S_CHECK)
        steps_q <= '0;
      else if (state == S_TRACE && handshake && !step_last)
        steps_q <= steps_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_path_tracer.sv
// Bench for path_tracer: a small grid model answers the read port, and a path model
// predicts the emitted steps and the done/fail outcome for each search.
module tb_path_tracer;

  localparam int GRID_W    = 5;
  localparam int GRID_H    = 4;
  localparam int XW        = 3;
  localparam int YW        = 2;
  localparam int SETTLE    = 8;
  localparam int MAX_STEPS = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          any_mod = 1'b0;
  logic          step_ready = 1'b0;
  logic [XW-1:0] src_x = '0, dst_x = '0;
  logic [YW-1:0] src_y = '0, dst_y = '0;
  logic          grid_rst, grid_clr, step_valid, step_last, busy, done, fail;
  logic [XW-1:0] clr_x, rd_x, step_x;
  logic [YW-1:0] clr_y, rd_y, step_y;
  logic [2:0]    rd_dir;
  logic [11:0]   rd_cost;

  logic [2:0]    dir_mem  [GRID_W][GRID_H];
  logic [11:0]   cost_mem [GRID_W][GRID_H];
  bit            mod_pat  [64];

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          last;
  } step_t;

  step_t exp_q[$];
  bit    exp_done;
  int    n_vec  = 0;
  int    n_miss = 0;

  path_tracer #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .XW(XW), .YW(YW),
    .SETTLE(SETTLE), .MAX_STEPS(MAX_STEPS)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_x(src_x), .src_y(src_y), .dst_x(dst_x), .dst_y(dst_y),
    .any_mod(any_mod), .grid_rst(grid_rst), .grid_clr(grid_clr),
    .clr_x(clr_x), .clr_y(clr_y), .rd_x(rd_x), .rd_y(rd_y),
    .rd_dir(rd_dir), .rd_cost(rd_cost),
    .step_valid(step_valid), .step_ready(step_ready),
    .step_x(step_x), .step_y(step_y), .step_last(step_last),
    .busy(busy), .done(done), .fail(fail)
  );

  always #5 clk = ~clk;

  // Combinational grid read port.
  always_comb begin
    rd_dir  = 3'd0;
    rd_cost = 12'hFFF;
    if (int'(rd_x) < GRID_W && int'(rd_y) < GRID_H) begin
      rd_dir  = dir_mem[int'(rd_x)][int'(rd_y)];
      rd_cost = cost_mem[int'(rd_x)][int'(rd_y)];
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int dx_of(input int d);
    case (d)
      1, 2, 3: return 1;
      5, 6, 7: return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int dy_of(input int d);
    case (d)
      0, 1, 7: return -1;
      3, 4, 5: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : (v < 0) ? -1 : 0;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Every node points one step toward the source, with an optional corruption rate.
  task automatic set_greedy_map(input int corrupt_pct);
    for (int x = 0; x < GRID_W; x++)
      for (int y = 0; y < GRID_H; y++) begin
        int sx, sy;
        sx = sgn(int'(src_x) - x);
        sy = sgn(int'(src_y) - y);
        dir_mem[x][y]  = 3'($urandom_range(0, 7));
        cost_mem[x][y] = 12'd0;
        for (int d = 0; d < 8; d++)
          if (dx_of(d) == sx && dy_of(d) == sy && (sx != 0 || sy != 0)) dir_mem[x][y] = 3'(d);
        if (int'($urandom_range(0, 99)) < corrupt_pct) dir_mem[x][y] = 3'($urandom_range(0, 7));
      end
  endtask

  task automatic clear_mods();
    for (int i = 0; i < 64; i++) mod_pat[i] = 1'b0;
  endtask

  // Path model: follow pointers from dst until src, the grid edge or the step limit.
  task automatic build_expected();
    int cx, cy, nx, ny;
    step_t s;
    exp_q.delete();
    exp_done = 1'b0;
    if (cost_mem[int'(dst_x)][int'(dst_y)] == 12'hFFF) return;
    cx = int'(dst_x);
    cy = int'(dst_y);
    for (int n = 0; n < MAX_STEPS; n++) begin
      s.x    = XW'(cx);
      s.y    = YW'(cy);
      s.last = (cx == int'(src_x)) && (cy == int'(src_y));
      exp_q.push_back(s);
      if (s.last) begin
        exp_done = 1'b1;
        return;
      end
      nx = cx + dx_of(int'(dir_mem[cx][cy]));
      ny = cy + dy_of(int'(dir_mem[cx][cy]));
      if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) return;
      cx = nx;
      cy = ny;
    end
  endtask

  // CHECK is entered the cycle after the first run of SETTLE quiet settle cycles.
  function automatic int expected_check_cycle();
    bit quiet;
    for (int c = 3 + SETTLE - 1; c < 64; c++) begin
      quiet = 1'b1;
      for (int j = c - SETTLE + 1; j <= c; j++) if (mod_pat[j]) quiet = 1'b0;
      if (quiet) return c + 1;
    end
    return 64;
  endfunction

  // ready_mode: 0 = always ready, 1 = random, 2 = hold off 5 cycles on the second step.
  task automatic apply_stimulus(input int ready_mode, input string name);
    int  c_chk, k, hold;
    bit  finished;
    build_expected();
    c_chk = expected_check_cycle();
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 1; c <= c_chk; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        check_output({name, ".grst"}, 32'({busy, grid_rst, grid_clr}), 32'b110);
        start = 1'b0;
      end else if (c == 2) begin
        check_output({name, ".seed"}, 32'({busy, grid_rst, grid_clr}), 32'b101);
        check_output({name, ".clr_addr"}, 32'({clr_x, clr_y}), 32'({src_x, src_y}));
      end else if (c < c_chk) begin
        check_output({name, ".settle"}, 32'({busy, grid_rst, grid_clr, step_valid, done, fail}),
                     32'b100000);
      end else begin
        check_output({name, ".check_rd"}, 32'({rd_x, rd_y, step_valid}), 32'({dst_x, dst_y, 1'b0}));
      end
      any_mod = mod_pat[c];
    end
    any_mod    = 1'b0;
    step_ready = 1'b0;
    k = 0;
    hold = 0;
    finished = 1'b0;
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      @(posedge clk); #1;
      if (k < exp_q.size()) begin
        check_output({name, ".step"}, 32'({step_valid, step_x, step_y, step_last}),
                     32'({1'b1, exp_q[k]}));
        case (ready_mode)
          0:       step_ready = 1'b1;
          1:       step_ready = 1'($urandom_range(0, 1));
          default: if (k == 1 && hold < 5) begin
                     step_ready = 1'b0;
                     hold++;
                   end else step_ready = 1'b1;
        endcase
        if (step_ready) k++;
      end else begin
        check_output({name, ".end_pulse"}, 32'({busy, step_valid, done, fail}),
                     32'({1'b1, 1'b0, exp_done, !exp_done}));
        step_ready = 1'b0;
        start      = 1'b1;
        finished   = 1'b1;
      end
    end
    if (!finished) check_output({name, ".trace_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    check_output({name, ".idle"}, 32'({busy, grid_rst, step_valid, done, fail}), 32'd0);
    start = 1'b0;
  endtask

  initial begin
    $display("[TB] path_tracer bench start");
    repeat (2) @(posedge clk);
    #1;
    check_output("reset", 32'({busy, grid_rst, grid_clr, step_valid, step_last, done, fail,
                               step_x, step_y, clr_x, clr_y, rd_x, rd_y}), 32'd0);
    rst = 1'b0;

    // Open grid diagonal walk.
    src_x = 3'd0; src_y = 2'd0; dst_x = 3'd3; dst_y = 2'd3;
    set_greedy_map(0);
    clear_mods();
    apply_stimulus(0, "open");

    // Source equals destination.
    src_x = 3'd2; src_y = 2'd1; dst_x = 3'd2; dst_y = 2'd1;
    set_greedy_map(0);
    apply_stimulus(0, "same");

    // Unreachable destination.
    src_x = 3'd0; src_y = 2'd0; dst_x = 3'd3; dst_y = 2'd3;
    set_greedy_map(0);
    cost_mem[3][3] = 12'hFFF;
    apply_stimulus(0, "unreach");

    // Backpressure on the second step.
    set_greedy_map(0);
    apply_stimulus(2, "bp");

    // Quiet-counter restart at count 7.
    clear_mods();
    mod_pat[10] = 1'b1;
    apply_stimulus(0, "settle");
    clear_mods();

    // Corrupt north pointer on the top row.
    src_x = 3'd4; src_y = 2'd3; dst_x = 3'd1; dst_y = 2'd0;
    set_greedy_map(0);
    dir_mem[1][0] = 3'd0;
    apply_stimulus(0, "corrupt");

    // East pointer on the last column.
    src_x = 3'd0; src_y = 2'd0; dst_x = 3'd4; dst_y = 2'd1;
    set_greedy_map(0);
    dir_mem[4][1] = 3'd2;
    apply_stimulus(1, "east_edge");

    // Two-node loop runs into the step limit.
    dst_x = 3'd2; dst_y = 2'd2;
    set_greedy_map(0);
    dir_mem[2][2] = 3'd2;
    dir_mem[3][2] = 3'd6;
    apply_stimulus(1, "loop");

    // Reset in the middle of a trace, then a clean search.
    src_x = 3'd0; src_y = 2'd0; dst_x = 3'd3; dst_y = 2'd3;
    set_greedy_map(0);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(posedge clk); #1;
        seen = step_valid;
      end
      check_output("midrst.reach_trace", 32'(seen), 32'd1);
    end
    step_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_output("midrst.zero", 32'({busy, grid_rst, grid_clr, step_valid, step_last, done, fail,
                                     step_x, step_y, clr_x, clr_y, rd_x, rd_y}), 32'd0);
    rst = 1'b0;
    step_ready = 1'b0;
    apply_stimulus(0, "after_rst");

    // Randomized searches with settle noise and random backpressure.
    for (int t = 0; t < 12; t++) begin
      src_x = XW'($urandom_range(0, GRID_W - 1));
      src_y = YW'($urandom_range(0, GRID_H - 1));
      dst_x = XW'($urandom_range(0, GRID_W - 1));
      dst_y = YW'($urandom_range(0, GRID_H - 1));
      set_greedy_map(int'($urandom_range(0, 25)));
      if ($urandom_range(0, 5) == 0) cost_mem[int'(dst_x)][int'(dst_y)] = 12'hFFF;
      clear_mods();
      for (int c = 1; c <= 14; c++) mod_pat[c] = ($urandom_range(0, 4) == 0);
      apply_stimulus(1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
